// File: rtl/gate_sweep_display_if.sv
// Board-side signal bundle for the gate sweep exerciser: raw switches and channel
// results in, stimulus bus and display out.
interface gate_sweep_display_if #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4,
  parameter int IN_W   = 4,
  parameter int LED_W  = 8
);
  logic [SEL_W-1:0]        sw_sel;
  logic [IN_W-1:0]         sw_in;
  logic                    btn_mode;
  logic [NUM_CH*LED_W-1:0] ch_data;
  logic [IN_W-1:0]         stim;
  logic [LED_W-1:0]        led;
  logic                    sweep_active;
  logic                    sample_pulse;

  modport master (
    output sw_sel, sw_in, btn_mode, ch_data,
    input  stim, led, sweep_active, sample_pulse
  );

  modport slave (
    input  sw_sel, sw_in, btn_mode, ch_data,
    output stim, led, sweep_active, sample_pulse
  );
endinterface

// File: rtl/gate_sweep_display.sv
// Gate library exerciser: debounced switch banks drive a shared stimulus bus either
// manually or by an automatic sweep, and the selected channel result is shown on led.
module gate_sweep_debounce #(
  parameter int W = 1,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  meta_reg, sync_reg, cand_reg, db_reg;
  logic [CW-1:0] cnt_reg;

  // cand_reg remembers the value being counted so a bounce to a different
  // non-debounced value restarts the count instead of continuing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
      cand_reg <= '0;
      db_reg   <= '0;
      cnt_reg  <= '0;
    end else begin
      meta_reg <= raw;
      sync_reg <= meta_reg;
      if (sync_reg == db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg != '0 && sync_reg != cand_reg) begin
        cnt_reg  <= CW'(1);
        cand_reg <= sync_reg;
      end else if (cnt_reg == CW'(N - 1)) begin
        db_reg  <= sync_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg  <= cnt_reg + 1'b1;
        cand_reg <= sync_reg;
      end
    end
  end

  assign db = db_reg;
endmodule

module gate_sweep_display #(
  parameter int NUM_CH          = 16,
  parameter int SEL_W           = 4,
  parameter int IN_W            = 4,
  parameter int LED_W           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 2,
  parameter int SWEEP_DIV       = 25000000
) (
  input logic                 clk,
  input logic                 rst,
  gate_sweep_display_if.slave bus
);
  localparam int SEL_N   = 1 << SEL_W;
  localparam int CNT_MAX = (SETTLE_CYCLES > SWEEP_DIV) ? SETTLE_CYCLES : SWEEP_DIV;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {MANUAL, SW_SETTLE, SW_HOLD} state_t;

  logic [SEL_W-1:0] sel_db;
  logic [IN_W-1:0]  in_db;
  logic             mode_db, mode_prev_reg, mode_evt;

  gate_sweep_debounce #(.W(SEL_W), .N(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .rst(rst), .raw(bus.sw_sel), .db(sel_db)
  );
  gate_sweep_debounce #(.W(IN_W), .N(DEBOUNCE_CYCLES)) u_db_in (
    .clk(clk), .rst(rst), .raw(bus.sw_in), .db(in_db)
  );
  gate_sweep_debounce #(.W(1), .N(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .raw(bus.btn_mode), .db(mode_db)
  );

  assign mode_evt = mode_db & ~mode_prev_reg;

  // Unpopulated select codes map to zero here and are replaced by the tag below.
  logic [LED_W-1:0] ch_arr [SEL_N];
  for (genvar gi = 0; gi < SEL_N; gi++) begin : g_ch
    if (gi < NUM_CH) begin : g_pop
      assign ch_arr[gi] = bus.ch_data[gi*LED_W +: LED_W];
    end else begin : g_empty
      assign ch_arr[gi] = '0;
    end
  end

  logic [SEL_W+3:0] sel_tag;
  logic [LED_W-1:0] sel_val;
  assign sel_tag = {4'b1010, sel_db};
  assign sel_val = ({1'b0, sel_db} < (SEL_W + 1)'(NUM_CH)) ? ch_arr[sel_db] : LED_W'(sel_tag);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IN_W-1:0]  stim_reg, stim_next;
  logic [LED_W-1:0] led_reg, led_next;
  logic             pulse_reg, pulse_next;
  logic             active_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= MANUAL;
      cnt_reg       <= '0;
      stim_reg      <= '0;
      led_reg       <= '0;
      pulse_reg     <= 1'b0;
      active_reg    <= 1'b0;
      mode_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      stim_reg      <= stim_next;
      led_reg       <= led_next;
      pulse_reg     <= pulse_next;
      active_reg    <= (state_next != MANUAL);
      mode_prev_reg <= mode_db;
    end
  end

  // A mode event leaving the sweep wins over counter expiry: no capture, no increment.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stim_next  = stim_reg;
    led_next   = led_reg;
    pulse_next = 1'b0;
    case (state_reg)
      MANUAL: begin
        stim_next = in_db;
        led_next  = sel_val;
        if (mode_evt) begin
          state_next = SW_SETTLE;
          stim_next  = '0;
          cnt_next   = '0;
        end
      end
      SW_SETTLE: begin
        if (mode_evt) begin
          state_next = MANUAL;
          stim_next  = in_db;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
          led_next   = sel_val;
          pulse_next = 1'b1;
          state_next = SW_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SW_HOLD: begin
        if (mode_evt) begin
          state_next = MANUAL;
          stim_next  = in_db;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(SWEEP_DIV - 1)) begin
          stim_next  = stim_reg + 1'b1;
          state_next = SW_SETTLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = MANUAL;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.stim         = stim_reg;
  assign bus.led          = led_reg;
  assign bus.sweep_active = active_reg;
  assign bus.sample_pulse = pulse_reg;
endmodule
